// File: rtl/scaled_feeder_pkg.sv
// Shared types and sizing helpers for the scaled line feeder.
package scaled_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FIRST = 2'd2
  } fetch_state_t;

  // Index width that never collapses to zero bits for tiny ranges.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Two-bank line store: one synchronous write port, one combinational read port.
module line_buffer
  import scaled_feeder_pkg::*;
#(
  parameter int PIX_W = 4,
  parameter int COLS  = 64,
  localparam int COL_W = idx_w(COLS)
) (
  input  logic             clk_25,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_col,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] bank_rd [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [PIX_W-1:0] mem [COLS];

      // Contents deliberately survive reset; only fetches overwrite them.
      always_ff @(posedge clk_25) begin
        if (wr_en && (wr_bank == 1'(gi))) begin
          mem[wr_col] <= wr_data;
        end
      end

      assign bank_rd[gi] = mem[rd_col];
    end
  endgenerate

  assign rd_data = bank_rd[rd_bank];

endmodule

// File: rtl/scaled_line_feeder.sv
// Double-buffered line feeder: fetches source rows from memory and replicates
// each pixel HSCALE times and each row VSCALE times on the display stream.
module scaled_line_feeder
  import scaled_feeder_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int COLS   = 64,
  parameter int ROWS   = 48,
  parameter int HSCALE = 10,
  parameter int VSCALE = 10,
  localparam int ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              disp_active,
  input  logic              line_end,
  input  logic              frame_end,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int COL_W = idx_w(COLS);
  localparam int ROW_W = idx_w(ROWS);
  localparam int H_W   = idx_w(HSCALE);
  localparam int V_W   = idx_w(VSCALE);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1 % ROWS);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(HSCALE - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(VSCALE - 1);

  generate
    if (COLS < 2) begin : g_chk_cols
      $error("scaled_line_feeder: COLS must be at least 2");
    end
    if (ROWS < 2) begin : g_chk_rows
      $error("scaled_line_feeder: ROWS must be at least 2");
    end
    if (HSCALE < 1 || HSCALE > 16) begin : g_chk_hscale
      $error("scaled_line_feeder: HSCALE must be in 1..16");
    end
    if (VSCALE < 1 || VSCALE > 16) begin : g_chk_vscale
      $error("scaled_line_feeder: VSCALE must be in 1..16");
    end
  endgenerate

  fetch_state_t     state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] fetch_row_reg, fetch_row_next;
  logic [H_W-1:0]   h_cnt_reg, h_cnt_next;
  logic [COL_W-1:0] h_pix_reg, h_pix_next;
  logic [V_W-1:0]   v_cnt_reg, v_cnt_next;
  logic [ROW_W-1:0] v_pix_reg, v_pix_next;
  logic             disp_sel_reg, disp_sel_next;
  logic             first_reg, first_next;
  logic             loaded_reg, loaded_next;
  logic             armed_reg, armed_next;
  logic             underrun_reg, underrun_next;

  logic             wr_en;
  logic             start_fetch;
  logic [ROW_W-1:0] start_row;
  logic [ROW_W-1:0] row_ahead;
  logic [PIX_W-1:0] rd_data;

  assign row_ahead = ROW_W'((int'(v_pix_reg) + 2) % ROWS);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      col_reg       <= '0;
      fetch_row_reg <= '0;
      h_cnt_reg     <= '0;
      h_pix_reg     <= '0;
      v_cnt_reg     <= '0;
      v_pix_reg     <= '0;
      disp_sel_reg  <= 1'b0;
      first_reg     <= 1'b0;
      loaded_reg    <= 1'b0;
      armed_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      fetch_row_reg <= fetch_row_next;
      h_cnt_reg     <= h_cnt_next;
      h_pix_reg     <= h_pix_next;
      v_cnt_reg     <= v_cnt_next;
      v_pix_reg     <= v_pix_next;
      disp_sel_reg  <= disp_sel_next;
      first_reg     <= first_next;
      loaded_reg    <= loaded_next;
      armed_reg     <= armed_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    fetch_row_next = fetch_row_reg;
    h_cnt_next     = h_cnt_reg;
    h_pix_next     = h_pix_reg;
    v_cnt_next     = v_cnt_reg;
    v_pix_next     = v_pix_reg;
    disp_sel_next  = disp_sel_reg;
    first_next     = first_reg;
    loaded_next    = loaded_reg;
    armed_next     = armed_reg;
    underrun_next  = 1'b0;
    wr_en          = 1'b0;
    start_fetch    = 1'b0;
    start_row      = '0;

    if (line_end) begin
      h_cnt_next = '0;
      h_pix_next = '0;
    end else if (disp_active) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        if (h_pix_reg != COL_LAST) begin
          h_pix_next = h_pix_reg + COL_W'(1);
        end
      end else begin
        h_cnt_next = h_cnt_reg + H_W'(1);
      end
    end

    case (state_reg)
      S_FETCH: begin
        if (mem_ack) begin
          wr_en = 1'b1;
          if (col_reg == COL_LAST) begin
            col_next   = '0;
            state_next = first_reg ? S_FIRST : S_IDLE;
          end else begin
            col_next = col_reg + COL_W'(1);
          end
        end
      end
      S_FIRST: begin
        disp_sel_next = ~disp_sel_reg;
        first_next    = 1'b0;
        loaded_next   = 1'b1;
        start_fetch   = 1'b1;
        start_row     = ROW_ONE;
      end
      default: ;
    endcase

    if (frame_end) begin
      v_cnt_next  = '0;
      v_pix_next  = '0;
      first_next  = 1'b1;
      armed_next  = 1'b1;
      start_fetch = 1'b1;
      start_row   = '0;
    end else if (line_end) begin
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next    = '0;
        v_pix_next    = (v_pix_reg == ROW_LAST) ? '0 : v_pix_reg + ROW_W'(1);
        disp_sel_next = ~disp_sel_next;
        // Until a frame_end has loaded real rows after reset, swaps neither
        // fetch nor expose the stale buffers.
        if (armed_reg) begin
          loaded_next   = 1'b1;
          start_fetch   = 1'b1;
          start_row     = row_ahead;
          underrun_next = (state_reg == S_FETCH);
        end
      end else begin
        v_cnt_next = v_cnt_reg + V_W'(1);
      end
    end

    // A (re)start discards any pixel acked for the abandoned fetch.
    if (start_fetch) begin
      state_next     = S_FETCH;
      col_next       = '0;
      fetch_row_next = start_row;
      wr_en          = 1'b0;
    end
  end

  line_buffer #(
    .PIX_W (PIX_W),
    .COLS  (COLS)
  ) u_line_buffer (
    .clk_25  (clk_25),
    .wr_en   (wr_en),
    .wr_bank (~disp_sel_reg),
    .wr_col  (col_reg),
    .wr_data (mem_data),
    .rd_bank (disp_sel_reg),
    .rd_col  (h_pix_reg),
    .rd_data (rd_data)
  );

  assign mem_req    = (state_reg == S_FETCH);
  assign fetch_busy = (state_reg == S_FETCH);
  assign mem_addr   = ADDR_W'(int'(fetch_row_reg) * COLS + int'(col_reg));
  assign pixel_out  = (disp_active && loaded_reg) ? rd_data : '0;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_scaled_line_feeder.sv
// Directed bench for scaled_line_feeder with COLS=8, ROWS=4, HSCALE=VSCALE=2;
// the memory model returns addr[3:0] as pixel data.
module tb_scaled_line_feeder;

  logic       clk_25 = 1'b0;
  logic       rst;
  logic       disp_active;
  logic       line_end;
  logic       frame_end;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic       mem_ack;
  logic [3:0] mem_data;
  logic [3:0] pixel_out;
  logic       fetch_busy;
  logic       underrun;

  int tests = 0;
  int fails = 0;

  scaled_line_feeder #(
    .PIX_W  (4),
    .COLS   (8),
    .ROWS   (4),
    .HSCALE (2),
    .VSCALE (2)
  ) dut (
    .clk_25      (clk_25),
    .rst         (rst),
    .disp_active (disp_active),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .pixel_out   (pixel_out),
    .fetch_busy  (fetch_busy),
    .underrun    (underrun)
  );

  always #5 clk_25 = ~clk_25;

  assign mem_data = mem_addr[3:0];

  task automatic tick();
    @(posedge clk_25);
    @(negedge clk_25);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic end_line();
    disp_active = 1'b0;
    line_end    = 1'b1;
    tick();
    line_end    = 1'b0;
  endtask

  // One 16-cycle active line; each source pixel appears twice.
  task automatic show_line(input int base, input string tag);
    for (int j = 0; j < 16; j++) begin
      disp_active = 1'b1;
      #1;
      chk(tag, 32'(pixel_out), 32'(base + j / 2));
      tick();
    end
    disp_active = 1'b0;
  endtask

  int gaps [16] = '{0, 3, 5, 1, 2, 4, 0, 5, 1, 0, 3, 2, 5, 4, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; disp_active = 1'b1; line_end = 1'b0; frame_end = 1'b0; mem_ack = 1'b1;
    tick(); tick();

    $display("[TB] step reset");
    #1;
    chk("rst_req",   32'(mem_req),    32'd0);
    chk("rst_addr",  32'(mem_addr),   32'd0);
    chk("rst_busy",  32'(fetch_busy), 32'd0);
    chk("rst_under", 32'(underrun),   32'd0);
    chk("rst_pix",   32'(pixel_out),  32'd0);
    disp_active = 1'b0;
    rst = 1'b0;
    tick();

    $display("[TB] step first load, ack always high");
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("load0_req", 32'(mem_req), 32'd1);
      chk("load0_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    chk("first_req", 32'(mem_req), 32'd0);
    chk("first_sel", 32'(dut.disp_sel_reg), 32'd0);
    tick();
    chk("swap_sel", 32'(dut.disp_sel_reg), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("load1_busy", 32'(fetch_busy), 32'd1);
      chk("load1_addr", 32'(mem_addr), 32'(8 + i));
      tick();
    end
    chk("load_done_busy", 32'(fetch_busy), 32'd0);
    chk("load_done_req",  32'(mem_req),    32'd0);

    $display("[TB] step active lines, row 0 twice then row 1");
    show_line(0, "line0a");
    end_line();
    show_line(0, "line0b");
    end_line();
    show_line(8, "line1");
    chk("line1_under", 32'(underrun), 32'd0);
    end_line();

    $display("[TB] step reload with ack gaps");
    mem_ack = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        mem_ack = 1'b0;
        chk("gap_first_req", 32'(mem_req), 32'd0);
        tick();
      end
      for (int g = 0; g < gaps[i]; g++) begin
        mem_ack = 1'b0;
        chk("gap_stall_req",  32'(mem_req),  32'd1);
        chk("gap_stall_addr", 32'(mem_addr), 32'(i));
        tick();
      end
      mem_ack = 1'b1;
      chk("gap_ack_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    mem_ack = 1'b0;
    chk("gap_done_busy", 32'(fetch_busy), 32'd0);
    show_line(0, "gap_line0");
    end_line();
    mem_ack = 1'b1;
    end_line();
    show_line(8, "gap_line1");

    $display("[TB] step underrun");
    mem_ack = 1'b0;
    end_line();
    end_line();
    chk("ur_start_addr",  32'(mem_addr), 32'd24);
    chk("ur_start_req",   32'(mem_req),  32'd1);
    chk("ur_start_under", 32'(underrun), 32'd0);
    tick();
    chk("ur_stall_addr", 32'(mem_addr), 32'd24);
    mem_ack = 1'b1;
    tick(); tick(); tick();
    mem_ack = 1'b0;
    chk("ur_col3_addr", 32'(mem_addr), 32'd27);
    end_line();
    chk("ur_hold_addr",  32'(mem_addr), 32'd27);
    chk("ur_hold_under", 32'(underrun), 32'd0);
    end_line();
    chk("ur_pulse",      32'(underrun),      32'd1);
    chk("ur_restart",    32'(mem_addr),      32'd0);
    chk("ur_restart_rq", 32'(mem_req),       32'd1);
    chk("ur_vpix",       32'(dut.v_pix_reg), 32'd3);
    tick();
    chk("ur_pulse_end", 32'(underrun), 32'd0);
    chk("ur_req_held",  32'(mem_req),  32'd1);

    $display("[TB] step frame_end with line_end");
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    chk("fl_pre_addr", 32'(mem_addr), 32'd2);
    end_line();
    frame_end = 1'b1;
    line_end  = 1'b1;
    tick();
    frame_end = 1'b0;
    line_end  = 1'b0;
    chk("fl_vpix",  32'(dut.v_pix_reg),    32'd0);
    chk("fl_vcnt",  32'(dut.v_cnt_reg),    32'd0);
    chk("fl_addr",  32'(mem_addr),         32'd0);
    chk("fl_req",   32'(mem_req),          32'd1);
    chk("fl_under", 32'(underrun),         32'd0);
    chk("fl_sel",   32'(dut.disp_sel_reg), 32'd0);

    $display("[TB] step reset mid-fetch");
    mem_ack = 1'b1;
    tick(); tick(); tick();
    chk("mr_col3_addr", 32'(mem_addr), 32'd3);
    disp_active = 1'b1;
    rst = 1'b1;
    #1;
    chk("mr_req",  32'(mem_req),    32'd0);
    chk("mr_addr", 32'(mem_addr),   32'd0);
    chk("mr_busy", 32'(fetch_busy), 32'd0);
    chk("mr_pix",  32'(pixel_out),  32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mr_idle_req", 32'(mem_req),   32'd0);
      chk("mr_idle_pix", 32'(pixel_out), 32'd0);
      tick();
    end
    frame_end = 1'b1;
    #1;
    chk("mr_fe_pix", 32'(pixel_out), 32'd0);
    tick();
    frame_end = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("mr_load_pix", 32'(pixel_out), 32'd0);
      tick();
    end
    end_line();
    show_line(0, "mr_line0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
